// File: rtl/csr_exec.sv
// Zicsr execute stage: reads the old CSR value, computes and issues a single write,
// then returns the old value for rd over a valid/ready response channel.
module csr_exec #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [4:0]      req_rs1_idx,
    input  logic [XLEN-1:0] req_rs1_val,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [4:0]      resp_rd,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_illegal,
    output logic            csr_wen,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_e;

    state_e          state_q;
    logic [2:0]      funct3_q;
    logic [11:0]     addr_q;
    logic [4:0]      rs1_idx_q;
    logic [XLEN-1:0] rs1_val_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] old_q;
    logic            illegal_q;
    logic            req_ready_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_data_q;
    logic            resp_illegal_q;
    logic            wen_q;
    logic [XLEN-1:0] wdata_q;

    logic [XLEN-1:0] opnd_d;
    logic            do_write_d;
    logic            illegal_d;
    logic            wen_d;
    logic [XLEN-1:0] wdata_d;

    // Evaluated during READ, where csr_rdata already reflects the latched address.
    always_comb begin
        opnd_d = '0;
        if (funct3_q[2]) begin
            opnd_d[4:0] = rs1_idx_q;
        end else begin
            opnd_d = rs1_val_q;
        end
        do_write_d = (funct3_q[1:0] == 2'b01) || (rs1_idx_q != '0);
        illegal_d  = (funct3_q[1:0] == 2'b00) || (do_write_d && (addr_q[11:10] == 2'b11));
        wen_d      = do_write_d && !illegal_d;
        unique case (funct3_q[1:0])
            2'b01:   wdata_d = opnd_d;
            2'b10:   wdata_d = csr_rdata | opnd_d;
            2'b11:   wdata_d = csr_rdata & ~opnd_d;
            default: wdata_d = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            funct3_q       <= '0;
            addr_q         <= '0;
            rs1_idx_q      <= '0;
            rs1_val_q      <= '0;
            rd_q           <= '0;
            old_q          <= '0;
            illegal_q      <= 1'b0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_illegal_q <= 1'b0;
            wen_q          <= 1'b0;
            wdata_q        <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        funct3_q    <= req_funct3;
                        addr_q      <= req_addr;
                        rs1_idx_q   <= req_rs1_idx;
                        rs1_val_q   <= req_rs1_val;
                        rd_q        <= req_rd;
                        req_ready_q <= 1'b0;
                        state_q     <= S_READ;
                    end
                end
                S_READ: begin
                    old_q     <= csr_rdata;
                    illegal_q <= illegal_d;
                    wen_q     <= wen_d;
                    wdata_q   <= wen_d ? wdata_d : '0;
                    state_q   <= S_WRITE;
                end
                S_WRITE: begin
                    wen_q          <= 1'b0;
                    wdata_q        <= '0;
                    resp_valid_q   <= 1'b1;
                    resp_illegal_q <= illegal_q;
                    resp_data_q    <= illegal_q ? '0 : old_q;
                    state_q        <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rd      = rd_q;
    assign resp_data    = resp_data_q;
    assign resp_illegal = resp_illegal_q;
    assign csr_addr     = addr_q;
    // The CSR file commits on the same edge that samples reset, so a reset landing in WRITE must mask the strobe.
    assign csr_wen      = wen_q & reset;
    assign csr_wdata    = reset ? wdata_q : '0;

endmodule
